// File: rtl/game_flow_controller.sv
// Pac-Man game sequencer: state machine, lives/level counters, movement tick and sprite reset.
// Define GAME_FLOW_PAUSE_EN to build the PAUSE state (start button toggles PLAY <-> PAUSE).
module game_flow_controller #(
  parameter int TICK_DIV    = 500000,
  parameter int READY_TICKS = 120,
  parameter int DEATH_TICKS = 90,
  parameter int LIVES       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       pacman_is_dead,
  input  logic       level_clear,
  output logic       move_tick,
  output logic       sprite_rst,
  output logic [2:0] game_state,
  output logic [1:0] lives,
  output logic [3:0] level
);

  localparam int DW   = $clog2(TICK_DIV);
  localparam int PMAX = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [PW-1:0] READY_LAST = PW'(READY_TICKS - 1);
  localparam logic [PW-1:0] DEATH_LAST = PW'(DEATH_TICKS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READY     = 3'd1,
    S_PLAY      = 3'd2,
    S_DEATH     = 3'd3,
    S_LEVEL_UP  = 3'd4,
    S_GAME_OVER = 3'd5
`ifdef GAME_FLOW_PAUSE_EN
    ,S_PAUSE    = 3'd6
`endif
  } state_t;

  state_t        state, state_next;
  logic          start_q;
  logic          start_edge;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] phase;
  logic          tick_raw;
  logic          state_change;
  logic          div_hold;
  logic          timed_state;
  logic [1:0]    lives_q, lives_next;
  logic [3:0]    level_q, level_next;

  assign start_edge   = start_btn & ~start_q;
  assign tick_raw     = (div_cnt == DIV_LAST);
  assign state_change = (state_next != state);
  assign timed_state  = (state == S_READY) || (state == S_DEATH) || (state == S_LEVEL_UP);

  // Entering, sitting in, or leaving PAUSE freezes the divider so PLAY resumes mid-period.
`ifdef GAME_FLOW_PAUSE_EN
  assign div_hold = (state == S_PAUSE) || (state_next == S_PAUSE);
`else
  assign div_hold = 1'b0;
`endif

  assign game_state = state;
  assign lives      = lives_q;
  assign level      = level_q;

  always_comb begin
    state_next = state;
    lives_next = lives_q;
    level_next = level_q;
    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (start_edge) begin
          state_next = S_READY;
          lives_next = LIVES_INIT;
          level_next = 4'd0;
        end
      end
      S_READY: begin
        if (tick_raw && (phase == READY_LAST)) state_next = S_PLAY;
      end
      S_PLAY: begin
        // Death takes priority over a simultaneous level clear.
        if (pacman_is_dead) begin
          state_next = S_DEATH;
          lives_next = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
        end else if (level_clear) begin
          state_next = S_LEVEL_UP;
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (start_edge) begin
          state_next = S_PAUSE;
        end
`endif
      end
      S_DEATH: begin
        if (tick_raw && (phase == DEATH_LAST))
          state_next = (lives_q == 2'd0) ? S_GAME_OVER : S_READY;
      end
      S_LEVEL_UP: begin
        if (tick_raw && (phase == DEATH_LAST)) begin
          state_next = S_READY;
          level_next = (level_q == 4'hf) ? 4'hf : level_q + 4'd1;
        end
      end
`ifdef GAME_FLOW_PAUSE_EN
      S_PAUSE: begin
        if (start_edge) state_next = S_PLAY;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      start_q    <= 1'b1;
      div_cnt    <= '0;
      phase      <= '0;
      lives_q    <= LIVES_INIT;
      level_q    <= 4'd0;
      move_tick  <= 1'b0;
      sprite_rst <= 1'b1;
    end else begin
      state   <= state_next;
      start_q <= start_btn;
      lives_q <= lives_next;
      level_q <= level_next;

      if (div_hold)          div_cnt <= div_cnt;
      else if (state_change) div_cnt <= '0;
      else if (tick_raw)     div_cnt <= '0;
      else                   div_cnt <= div_cnt + DW'(1);

      // Phase only advances in timed states; it is cleared before it can exceed PMAX-1.
      if (state_change)                 phase <= '0;
      else if (tick_raw && timed_state) phase <= phase + PW'(1);

      // A tick coinciding with leaving PLAY is dropped so sprites never move on a transition.
      move_tick  <= tick_raw && (state == S_PLAY) && (state_next == S_PLAY);
      sprite_rst <= (state_next == S_IDLE) || (state_next == S_READY) ||
                    (state_next == S_GAME_OVER);
    end
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level game sequencer for the Pac-Man backend. It owns the game state machine (idle, ready, play, death, level-up, game over) and the lives and level counters. It derives the sprite-movement tick from the system clock and drives the sprite reset that returns all sprites to their start positions. The game logic advances positions only on `move_tick` and is held in reset by `sprite_rst`; `game_state`, `lives` and `level` feed the display frontend.

## Interface
- `TICK_DIV`, 500000: clk cycles per movement tick; must be ≥2.
- `READY_TICKS`, 120: movement-tick periods spent in READY; must be ≥1.
- `DEATH_TICKS`, 90: tick periods spent in DEATH and in LEVEL_UP; must be ≥1.
- `LIVES`, 3: lives at game start, range 1–3.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_btn`  in  1  level from the start button, already debounced.
- `pacman_is_dead`  in  1  collision flag from the game logic.
- `level_clear`  in  1  all pellets eaten, from the pellet map.
- `move_tick`  out  1  one-cycle enable for the sprite position update.
- `sprite_rst`  out  1  active-high reset into the game logic.
- `game_state`  out  3  IDLE=0, READY=1, PLAY=2, DEATH=3, LEVEL_UP=4, GAME_OVER=5, PAUSE=6.
- `lives`  out  2  remaining lives.
- `level`  out  4  current level, starting at 0.

## Operation
- **Start-edge detector.** `start_q` registers `start_btn`. `start_edge = start_btn & ~start_q`. `start_q` resets to 1, so a button held through reset release gives no edge.
- **Divider.** Counter of width $clog2(TICK_DIV) counts 0..TICK_DIV-1 and wraps. `tick_raw` is high when the counter is at TICK_DIV-1. The counter clears to 0 on every state change.
- **Phase counter.** Counts `tick_raw` pulses and clears on every state change.
- **FSM:**
  - IDLE: on `start_edge` → READY; set lives=LIVES, level=0.
  - READY: when the phase count reaches READY_TICKS → PLAY.
  - PLAY, when `pacman_is_dead` is sampled high → DEATH; lives decrement by 1.
  - PLAY, else when `level_clear` is sampled high → LEVEL_UP. Death wins when both are high in the same cycle.
  - DEATH: when the phase count reaches DEATH_TICKS → GAME_OVER if lives==0, else READY.
  - LEVEL_UP: when the phase count reaches DEATH_TICKS → READY; level increments, saturating at 15.
  - GAME_OVER: on `start_edge` → READY; set lives=LIVES, level=0.
- **`move_tick`** is `tick_raw` qualified by state==PLAY, registered.
- **`sprite_rst`** is 1 in IDLE, READY and GAME_OVER, and 0 otherwise. Sprites stay frozen in place during DEATH, LEVEL_UP and PAUSE.
- **Ignored inputs.** `pacman_is_dead` and `level_clear` are ignored outside PLAY. `start_btn` is ignored in READY, DEATH and LEVEL_UP.

## Timing
- **Reset values:** game_state=IDLE, sprite_rst=1, move_tick=0, lives=LIVES, level=0, divider=0, phase=0.
- **Registered outputs.** All outputs are registered. A qualifying input sampled at edge k gives the new state and counter values after edge k.
- **Phase lengths.** Entering a timed state at cycle N, the state exits at N + ticks×TICK_DIV (ticks = READY_TICKS or DEATH_TICKS).
- **First move tick.** The first `move_tick` after entering PLAY at cycle N is high during cycle N+TICK_DIV; after that it repeats every TICK_DIV cycles.
- **Exact counts.** No `move_tick` is emitted in the cycle of a state change. A death on the last life leaves lives=0.
- **Reset mid-operation.** Asserting `rst_n` low forces all registers to their reset values immediately, regardless of state or counter phase.

## Configuration
- **`GAME_FLOW_PAUSE_EN` defined:**
  - In PLAY, `start_edge` → PAUSE (state code 6).
  - In PAUSE, `start_edge` → PLAY.
  - PAUSE emits no `move_tick`, holds the divider, and ignores `pacman_is_dead` and `level_clear`.
  - On return to PLAY, the divider resumes from its held value and is not cleared.
- **Undefined:** the PAUSE state is not built, and `start_btn` is ignored in PLAY.

## Test plan
Bench parameters: TICK_DIV=4, READY_TICKS=2, DEATH_TICKS=2, LIVES=2.

- Reset, then a `start_btn` pulse → READY with lives=2 and level=0; PLAY exactly 8 cycles after READY entry; first `move_tick` 4 cycles after PLAY entry, then every 4 cycles.
- In PLAY, assert `pacman_is_dead` → DEATH next cycle with lives=1 and `move_tick` silent; after 8 cycles → READY with `sprite_rst`=1.
- A second death → lives=0 → GAME_OVER after 8 cycles; a `start_btn` pulse → READY with lives=2 and level=0.
- `pacman_is_dead` and `level_clear` high in the same PLAY cycle → DEATH, and level is unchanged.
- Sixteen level clears → level saturates at 15. Also: `start_btn` held through reset release → stays IDLE until the button is released and pressed again.
- Pause macro defined: `start_btn` pulse in PLAY → state code 6 with no ticks; a second pulse resumes PLAY. Also: `rst_n` low mid-DEATH → immediately IDLE with lives=2.
